// File: rtl/dct8_row_engine_if.sv
// rtl/dct8_row_engine_if.sv - sample-in / coefficient-out stream bundle of the DCT8 row engine
interface dct8_row_engine_if #(
  parameter int IW = 12,
  parameter int OW = 16
);
  logic          clr;
  logic          mode;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic [2:0]    out_index;
  logic          out_sat;
  logic          blk_done;

  modport master (output clr, mode, in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data, out_index, out_sat, blk_done);
  modport slave  (input  clr, mode, in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, out_index, out_sat, blk_done);
endinterface

// File: rtl/dct8_row_engine.sv
// rtl/dct8_row_engine.sv - streaming 8-point DCT/IDCT row engine (Q1.7 table, round + saturate)
// Optional LEVEL_SHIFT_EN: treat in_data as unsigned and subtract 2^(IW-1) before the multiply.
module dct8_row_engine #(
  parameter int IW   = 12,
  parameter int OW   = 16,
  parameter int FRAC = 7,
  parameter int AW   = IW + 13
) (
  input logic              clk,
  input logic              rst_n,
  dct8_row_engine_if.slave bus
);
  typedef enum logic {LOAD, DRAIN} state_t;

  localparam logic signed [AW:0] RND  = (AW+1)'(2 ** (FRAC - 1));
  localparam logic signed [AW:0] MAXV = (AW+1)'(2 ** (OW - 1) - 1);
  localparam logic signed [AW:0] MINV = (AW+1)'(-(2 ** (OW - 1)));

  // C[u][x] = a_u*cos((2x+1)u*pi/16) in Q1.7, folded onto the quarter-wave magnitudes.
  function automatic logic signed [8:0] coeff(input logic [2:0] u, input logic [2:0] x);
    logic [4:0]        m;
    logic [5:0]        r;
    logic [3:0]        k;
    logic              neg;
    logic signed [8:0] mag;
    m   = 5'({x, 1'b1}) * 5'(u);
    r   = (m > 5'd16) ? (6'd32 - {1'b0, m}) : {1'b0, m};
    neg = (r > 6'd8);
    k   = neg ? 4'(6'd16 - r) : r[3:0];
    case (k)
      4'd1:    mag = 9'sd125;
      4'd2:    mag = 9'sd118;
      4'd3:    mag = 9'sd106;
      4'd4:    mag = 9'sd90;
      4'd5:    mag = 9'sd71;
      4'd6:    mag = 9'sd49;
      4'd7:    mag = 9'sd25;
      default: mag = 9'sd0;
    endcase
    if (u == 3'd0) return 9'sd90;
    return neg ? -mag : mag;
  endfunction

  state_t                state;
  logic [2:0]            idx;
  logic                  mode_q;
  logic signed [AW-1:0]  acc      [8];
  logic signed [AW-1:0]  acc_nxt  [8];
  logic signed [8:0]     coef     [8];
  logic signed [AW-1:0]  prod     [8];
  logic signed [IW:0]    s;
  logic                  mode_eff;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic [OW-1:0]         out_data_q;
  logic [2:0]            out_index_q;
  logic                  out_sat_q;
  logic                  blk_done_q;
  logic [2:0]            nxt_index;
  logic signed [AW-1:0]  drain_src;
  logic signed [AW:0]    rnd_sum;
  logic signed [AW:0]    rnd_val;
  logic [OW-1:0]         rs_data;
  logic                  rs_sat;

  always_comb begin
`ifdef LEVEL_SHIFT_EN
    s = $signed({1'b0, bus.in_data}) - $signed((IW+1)'(2 ** (IW - 1)));
`else
    s = $signed({bus.in_data[IW-1], bus.in_data});
`endif
  end

  // Mode only matters from sample 0 onward; later toggles are masked by mode_q.
  assign mode_eff = (idx == 3'd0) ? bus.mode : mode_q;

  always_comb begin
    for (int j = 0; j < 8; j++) begin
      coef[j]    = mode_eff ? coeff(idx, 3'(j)) : coeff(3'(j), idx);
      prod[j]    = AW'(coef[j]) * AW'(s);
      acc_nxt[j] = acc[j] + prod[j];
    end
  end

  // Output register is loaded one coefficient ahead: acc_nxt[0] on the 8th sample, else acc[index+1].
  assign nxt_index = out_index_q + 3'd1;
  assign drain_src = (state == LOAD) ? acc_nxt[0] : acc[nxt_index];

  always_comb begin
    rnd_sum = (AW+1)'(drain_src) + RND;
    rnd_val = rnd_sum >>> FRAC;
    rs_sat  = 1'b0;
    rs_data = rnd_val[OW-1:0];
    if (rnd_val > MAXV) begin
      rs_sat  = 1'b1;
      rs_data = MAXV[OW-1:0];
    end else if (rnd_val < MINV) begin
      rs_sat  = 1'b1;
      rs_data = MINV[OW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= LOAD;
      idx         <= 3'd0;
      mode_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= 3'd0;
      out_sat_q   <= 1'b0;
      blk_done_q  <= 1'b0;
      for (int j = 0; j < 8; j++) acc[j] <= '0;
    end else if (bus.clr) begin
      state       <= LOAD;
      idx         <= 3'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_index_q <= 3'd0;
      blk_done_q  <= 1'b0;
      for (int j = 0; j < 8; j++) acc[j] <= '0;
    end else begin
      blk_done_q <= 1'b0;
      case (state)
        LOAD: begin
          if (bus.in_valid) begin
            for (int j = 0; j < 8; j++) acc[j] <= acc_nxt[j];
            idx <= idx + 3'd1;
            if (idx == 3'd0) mode_q <= bus.mode;
            if (idx == 3'd7) begin
              state       <= DRAIN;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_index_q <= 3'd0;
              out_data_q  <= rs_data;
              out_sat_q   <= rs_sat;
            end
          end
        end
        DRAIN: begin
          if (bus.out_ready) begin
            if (out_index_q == 3'd7) begin
              state       <= LOAD;
              in_ready_q  <= 1'b1;
              out_valid_q <= 1'b0;
              out_index_q <= 3'd0;
              blk_done_q  <= 1'b1;
              for (int j = 0; j < 8; j++) acc[j] <= '0;
            end else begin
              out_index_q <= nxt_index;
              out_data_q  <= rs_data;
              out_sat_q   <= rs_sat;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_index = out_index_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.blk_done  = blk_done_q;
endmodule
